// File: rtl/nor_slice_sequencer.sv
// rtl/nor_slice_sequencer.sv - time-shared 4-bit logic slice sequencing AND/OR/NOR/XOR over a WIDTH-bit operand pair
// Result is assembled in a shadow register and published whole on completion.
module nor_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_output;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  int               w_base;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_shadow_next;

  // start is only honoured outside RUN; DONE accepts it for back-to-back operation
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = w_accept ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_comb begin
    w_base = int'(r_cnt) * SLICE;
    w_sa   = r_a[w_base +: SLICE];
    w_sb   = r_b[w_base +: SLICE];
    case (r_op)
      2'b00:   w_slice = w_sa & w_sb;
      2'b01:   w_slice = w_sa | w_sb;
      2'b10:   w_slice = ~(w_sa | w_sb);
      default: w_slice = w_sa ^ w_sb;
    endcase
  end

  always_comb begin
    w_shadow_next                   = r_shadow;
    w_shadow_next[w_base +: SLICE] = w_slice;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_shadow <= '0;
      r_output <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= input1;
      r_b      <= input2;
      r_op     <= op;
      r_shadow <= '0;
    end else if (r_state == S_RUN) begin
      r_shadow <= w_shadow_next;
      // Output only ever sees the fully assembled word, merged with the final slice
      if (w_last) begin
        r_output <= w_shadow_next;
        r_zero   <= (w_shadow_next == '0);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Output = r_output;
  assign zero   = r_zero;

endmodule
